// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: EX/MEM control bundle, load/store size codes and MEM-stage FSM states.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_funct3;
  } ctrl_signals_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    DONE     = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory valid/ready request bus with a one-cycle load response pulse.
interface mem_stage_if;
  import riscv_pkg::*;

  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic [XLEN-1:0] dmem_req_addr;
  logic            dmem_req_we;
  logic [BE_W-1:0] dmem_req_be;
  logic [XLEN-1:0] dmem_req_wdata;
  logic            dmem_rsp_valid;
  logic [XLEN-1:0] dmem_rsp_rdata;

  modport master (
    output dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_be, dmem_req_wdata,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_be, dmem_req_wdata,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );

endinterface

// File: rtl/mem_stage_align.sv
// Combinational byte-lane logic: store enables/replication, load extract/extend, alignment check.
module mem_align
  import riscv_pkg::*;
(
  input  logic            access_i,
  input  logic            is_store_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_off_i,
  input  logic [XLEN-1:0] ld_rdata_i,
  output logic            misaligned_c_o,
  output logic [BE_W-1:0] st_be_c_o,
  output logic [XLEN-1:0] st_wdata_c_o,
  output logic [XLEN-1:0] ld_data_c_o
);

  logic        is_byte;
  logic        is_half;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;

  // Stores only know B/H/W; any other code falls back to word size
  always_comb begin
    if (is_store_i) begin
      is_byte = (funct3_i == F3_B);
      is_half = (funct3_i == F3_H);
    end else begin
      is_byte = (funct3_i == F3_B) || (funct3_i == F3_BU);
      is_half = (funct3_i == F3_H) || (funct3_i == F3_HU);
    end
  end

  assign misaligned_c_o = access_i &
                          (is_half ? addr_lo_i[0] : (!is_byte && (addr_lo_i != 2'b00)));

  always_comb begin
    st_be_c_o    = '0;
    st_wdata_c_o = '0;
    if (access_i && !misaligned_c_o) begin
      if (!is_store_i) begin
        st_be_c_o = 4'hF;
      end else if (is_byte) begin
        st_be_c_o    = 4'b0001 << addr_lo_i;
        st_wdata_c_o = {4{rs2_data_i[7:0]}};
      end else if (is_half) begin
        st_be_c_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        st_wdata_c_o = {2{rs2_data_i[15:0]}};
      end else begin
        st_be_c_o    = 4'hF;
        st_wdata_c_o = rs2_data_i;
      end
    end
  end

  assign ld_half = 16'(ld_rdata_i >> {ld_off_i, 3'b000});
  assign ld_byte = ld_half[7:0];

  always_comb begin
    case (ld_funct3_i)
      F3_B:    ld_data_c_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_c_o = {24'd0, ld_byte};
      F3_H:    ld_data_c_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_c_o = {16'd0, ld_half};
      default: ld_data_c_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: drives the data-memory bus, stalls the pipeline while a load is outstanding.
module mem_stage
  import riscv_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  ctrl_signals_t      ctrl_in,
  input  logic [XLEN-1:0]    alu_result_in,
  input  logic [XLEN-1:0]    rs2_data_in,
  mem_stage_if.master        dmem,
  output logic [XLEN-1:0]    mem_rdata_out,
  output logic               mem_stall,
  output logic               misaligned_out
);

  mem_state_t      state_q, state_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            access;
  logic            is_store;
  logic            mis;
  logic [BE_W-1:0] st_be;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] ld_data;
  logic            req_valid;

  assign access   = ctrl_in.mem_read | ctrl_in.mem_write;
  assign is_store = ctrl_in.mem_write;

  mem_align u_align (
    .access_i       (access),
    .is_store_i     (is_store),
    .funct3_i       (ctrl_in.mem_funct3),
    .addr_lo_i      (alu_result_in[1:0]),
    .rs2_data_i     (rs2_data_in),
    .ld_funct3_i    (f3_q),
    .ld_off_i       (off_q),
    .ld_rdata_i     (dmem.dmem_rsp_rdata),
    .misaligned_c_o (mis),
    .st_be_c_o      (st_be),
    .st_wdata_c_o   (st_wdata),
    .ld_data_c_o    (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      off_q   <= 2'd0;
      f3_q    <= 3'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
    end
  end

  // DONE never reissues: EX/MEM still holds the finished load for that one cycle
  always_comb begin
    state_d       = state_q;
    off_d         = off_q;
    f3_d          = f3_q;
    rdata_d       = rdata_q;
    req_valid     = 1'b0;
    mem_stall     = 1'b0;
    mem_rdata_out = '0;
    case (state_q)
      IDLE: begin
        if (access && !mis) begin
          req_valid = 1'b1;
          if (is_store) begin
            mem_stall = !dmem.dmem_req_ready;
          end else begin
            mem_stall = 1'b1;
            if (dmem.dmem_req_ready) begin
              off_d   = alu_result_in[1:0];
              f3_d    = ctrl_in.mem_funct3;
              state_d = WAIT_RSP;
            end
          end
        end
      end
      WAIT_RSP: begin
        mem_stall = 1'b1;
        if (dmem.dmem_rsp_valid) begin
          rdata_d = ld_data;
          state_d = DONE;
        end
      end
      DONE: begin
        mem_rdata_out = rdata_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign misaligned_out      = mis;
  assign dmem.dmem_req_valid = req_valid;
  assign dmem.dmem_req_addr  = {alu_result_in[XLEN-1:2], 2'b00};
  assign dmem.dmem_req_we    = is_store & !mis;
  assign dmem.dmem_req_be    = st_be;
  assign dmem.dmem_req_wdata = st_wdata;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RV32I pipeline, directly downstream of the EX/MEM pipeline register. Takes the registered control bundle, ALU result (effective address) and rs2 data, and drives a valid/ready data-memory bus. Formats store byte-lanes and load data (extract + sign/zero extend), and raises a pipeline stall while a memory transaction is outstanding. Its load result and `ctrl`/`rd` path feed the MEM/WB register.

## Interface
- No parameters; XLEN fixed at 32.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ctrl_in` in `riscv_pkg::ctrl_signals_t`: from EX/MEM; uses `mem_read`, `mem_write`, `mem_funct3`.
- `alu_result_in` in 32: effective byte address.
- `rs2_data_in` in 32: store data.
- `dmem_req_valid` out 1: request valid.
- `dmem_req_ready` in 1: memory accepts request this cycle.
- `dmem_req_addr` out 32: word-aligned address, `{alu_result_in[31:2],2'b00}`.
- `dmem_req_we` out 1: 1 = store.
- `dmem_req_be` out 4: byte enables.
- `dmem_req_wdata` out 32: lane-replicated store data.
- `dmem_rsp_valid` in 1: load response valid (one-cycle pulse).
- `dmem_rsp_rdata` in 32: load response word.
- `mem_rdata_out` out 32: formatted load data, valid in DONE.
- `mem_stall` out 1: freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB.
- `misaligned_out` out 1: misaligned access detected (combinational).

## Operation
- Access = `mem_read | mem_write`; `mem_write` wins if both set.
- Misaligned: word with `addr[1:0]!=0`, half with `addr[0]!=0`. Misaligned access: no request, `misaligned_out=1`, `mem_stall=0`, `mem_rdata_out=0`.
- FSM states IDLE, WAIT_RSP, DONE.
  - IDLE, no access: `valid=0`, `stall=0`.
  - IDLE, store: `valid=1`, `we=1`. With `ready=1`: `stall=0`, stay IDLE. With `ready=0`: `stall=1`, hold request.
  - IDLE, load: `valid=1`, `stall=1`. With `ready=1`: latch `addr[1:0]` and `funct3`, go WAIT_RSP.
  - WAIT_RSP: `valid=0`, `stall=1`. On `rsp_valid`, register the formatted data into `rdata_q` and go DONE.
  - DONE: `valid=0`, `stall=0`, `mem_rdata_out=rdata_q`. The request is not reissued although `ctrl_in` is unchanged. Next state is IDLE unconditionally.
- `mem_rdata_out=0` outside DONE.
- `dmem_rsp_valid` outside WAIT_RSP is ignored.
- Once `valid=1` in IDLE, the request fields stay stable until `ready` (EX/MEM is frozen by stall).
- Store formatting:
  - SB: `be=4'b0001<<addr[1:0]`, `wdata={4{rs2[7:0]}}`.
  - SH: `be=4'b0011<<{addr[1],1'b0}`, `wdata={2{rs2[15:0]}}`.
  - SW: `be=4'hF`, `wdata=rs2`.
- Loads: `be=4'hF`, `wdata=0`.
- Load formatting: `w = rdata >> (8*off)`.
  - LB: `sext(w[7:0])`. LBU: `zext(w[7:0])`.
  - LH: `sext(w[15:0])`. LHU: `zext(w[15:0])`.
  - LW: `rdata`.
- Unsupported `funct3` is treated as LW/SW.

## Timing
- Reset: state IDLE, `rdata_q=0`. `valid`/`we`/`be`/`wdata`/`addr` follow `ctrl_in` (0 when `ctrl_in='0`). `mem_stall=0`, `mem_rdata_out=0`, `misaligned_out=0`.
- Store with `ready` high: zero added cycles.
- Load: request cycle, ≥1 WAIT_RSP cycle, 1 DONE cycle. Minimum load-to-writeback is 2 stall cycles plus DONE.
- `ready`→`stall` and `rsp` paths are combinational through IDLE; `rdata` is registered.
- Reset mid-transaction: FSM to IDLE and outstanding response dropped. The memory side must discard it too.
- Back-to-back loads: DONE→IDLE; the next load issues in the first IDLE cycle.

## Structure
- `riscv_pkg` additions:
  - `ctrl_signals_t` fields `mem_read`, `mem_write`, `mem_funct3[2:0]`.
  - Constants `F3_B=3'b000`, `F3_H=3'b001`, `F3_W=3'b010`, `F3_BU=3'b100`, `F3_HU=3'b101`.
  - `mem_state_t` enum (IDLE, WAIT_RSP, DONE).
- Sub-module `mem_align` (combinational): store `be`/`wdata` generation, load extract/extend, misalignment check.
- `mem_stage` holds the FSM, latches and handshake.

## Test plan
- SW addr `0x100`, `rs2=0xDEADBEEF`, `ready=1` → one request: `addr 0x100`, `be 1111`, `wdata 0xDEADBEEF`, `we=1`, `stall` never high.
- SB addr `0x103`, `rs2=0x000000A5`, `ready` low for 2 cycles → `valid` held 3 cycles, `be 1000`, `wdata 0xA5A5A5A5`, `stall` high 2 cycles.
- LB addr `0x102`, rsp `0x12F03456` after 3 cycles → `mem_rdata_out=0xFFFFFFF0` in DONE. LBU same → `0x000000F0`. `stall` high request+WAIT cycles only.
- LH addr `0x101` → `misaligned_out=1`, no `valid`, `stall=0`. LW addr `0x104` → aligned, normal.
- Stray `rsp_valid` in IDLE with no load → no state change. Reset asserted in WAIT_RSP → IDLE, `stall=0`, `mem_rdata_out=0`.
- Two back-to-back LW (`0x200`, `0x204`), zero-wait memory → two requests, DONE between them, no reissue during DONE.
